// File: rtl/regfile_wb_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_if
// Bundles the write-back, issue and read-port signals of regfile_wb.
//   master : drives write-back, issue and read addresses; receives read data,
//            busy bits and the write-back pending flag.
//   slave  : the register file side.
// Signals:
//   wb_valid/wb_addr/wb_data    write request from the write-data selector
//   iss_valid/iss_addr          decode issue that marks a destination busy
//   rd_addr_a/rd_addr_b         read addresses
//   rd_data_a/rd_data_b         combinational read data
//   busy_a/busy_b               scoreboard bits for the read addresses
//   wb_pend                     staged write awaiting commit
// ---------------------------------------------------------------------------
interface regfile_wb_if #(
    parameter int DATAWIDTH = 16,
    parameter int ADDRWIDTH = 4
);
    logic                 wb_valid;
    logic [ADDRWIDTH-1:0] wb_addr;
    logic [DATAWIDTH-1:0] wb_data;
    logic                 iss_valid;
    logic [ADDRWIDTH-1:0] iss_addr;
    logic [ADDRWIDTH-1:0] rd_addr_a;
    logic [ADDRWIDTH-1:0] rd_addr_b;
    logic [DATAWIDTH-1:0] rd_data_a;
    logic [DATAWIDTH-1:0] rd_data_b;
    logic                 busy_a;
    logic                 busy_b;
    logic                 wb_pend;

    modport master (
        output wb_valid, wb_addr, wb_data,
        output iss_valid, iss_addr,
        output rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, busy_a, busy_b, wb_pend
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data,
        input  iss_valid, iss_addr,
        input  rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, busy_a, busy_b, wb_pend
    );
endinterface

// File: rtl/regfile_wb.sv
// ---------------------------------------------------------------------------
// regfile_wb
// Write-back register file for the 16-bit datapath. A write is staged for one
// cycle in a write-back register, then committed to a 16-entry array. Two
// combinational read ports bypass from the staged write. A per-register busy
// scoreboard marks destinations of issued instructions until their commit.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    regfile_wb_if.slave (write-back, issue, read ports, status)
// ---------------------------------------------------------------------------
module regfile_wb #(
    parameter int DATAWIDTH = 16,
    parameter int ADDRWIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_wb_if.slave   bus
);
    localparam int NREGS = 2 ** ADDRWIDTH;

    logic [DATAWIDTH-1:0] regs_q [NREGS];
    logic [DATAWIDTH-1:0] regs_d [NREGS];
    logic                 pend_valid_q, pend_valid_d;
    logic [ADDRWIDTH-1:0] pend_addr_q,  pend_addr_d;
    logic [DATAWIDTH-1:0] pend_data_q,  pend_data_d;
    logic [NREGS-1:0]     busy_q,       busy_d;

    // Staged write takes priority over the array so a read sees the newest
    // value while its commit is still one edge away.
    function automatic logic [DATAWIDTH-1:0] read_port(
        input logic [ADDRWIDTH-1:0] addr,
        input logic [DATAWIDTH-1:0] arr_word,
        input logic                 stg_valid,
        input logic [ADDRWIDTH-1:0] stg_addr,
        input logic [DATAWIDTH-1:0] stg_data
    );
        if (stg_valid && (stg_addr == addr)) begin
            return stg_data;
        end
        return arr_word;
    endfunction

    always_comb begin
        regs_d       = regs_q;
        pend_valid_d = bus.wb_valid;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        busy_d       = busy_q;

        // Commit of the previously staged write.
        if (pend_valid_q) begin
            regs_d[pend_addr_q] = pend_data_q;
            busy_d[pend_addr_q] = 1'b0;
        end

        // Issue is applied after the commit clear so that a same-register
        // set and clear on one edge leaves the register busy.
        if (bus.iss_valid) begin
            busy_d[bus.iss_addr] = 1'b1;
        end

        if (bus.wb_valid) begin
            pend_addr_d = bus.wb_addr;
            pend_data_d = bus.wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            busy_q       <= '0;
        end else begin
            regs_q       <= regs_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.rd_data_a = read_port(bus.rd_addr_a, regs_q[bus.rd_addr_a],
                                     pend_valid_q, pend_addr_q, pend_data_q);
    assign bus.rd_data_b = read_port(bus.rd_addr_b, regs_q[bus.rd_addr_b],
                                     pend_valid_q, pend_addr_q, pend_data_q);
    assign bus.busy_a    = busy_q[bus.rd_addr_a];
    assign bus.busy_b    = busy_q[bus.rd_addr_b];
    assign bus.wb_pend   = pend_valid_q;

endmodule

// File: tb/tb_regfile_wb.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb
// Self-checking bench for regfile_wb. Expected values are pushed to a
// scoreboard queue as stimulus is driven and popped/compared against the
// DUT outputs between clock edges.
// ---------------------------------------------------------------------------
module tb_regfile_wb;
    localparam int SEL_RDA   = 0;
    localparam int SEL_RDB   = 1;
    localparam int SEL_BUSYA = 2;
    localparam int SEL_BUSYB = 3;
    localparam int SEL_PEND  = 4;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] exp;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    exp_t sb_q[$];

    regfile_wb_if #(.DATAWIDTH(16), .ADDRWIDTH(4)) bus_if ();

    regfile_wb #(.DATAWIDTH(16), .ADDRWIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_if.wb_valid  = 1'b0;
        bus_if.iss_valid = 1'b0;
    endtask

    task automatic drive_wb(input logic [3:0] addr, input logic [15:0] data);
        bus_if.wb_valid = 1'b1;
        bus_if.wb_addr  = addr;
        bus_if.wb_data  = data;
    endtask

    task automatic drive_iss(input logic [3:0] addr);
        bus_if.iss_valid = 1'b1;
        bus_if.iss_addr  = addr;
    endtask

    task automatic set_rd(input logic [3:0] a, input logic [3:0] b);
        bus_if.rd_addr_a = a;
        bus_if.rd_addr_b = b;
    endtask

    task automatic expect_out(input string tag, input int sel, input logic [15:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Let combinational outputs settle, then compare every queued expectation.
    task automatic drain();
        exp_t        e;
        logic [15:0] obs;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                SEL_RDA:   obs = bus_if.rd_data_a;
                SEL_RDB:   obs = bus_if.rd_data_b;
                SEL_BUSYA: obs = {15'd0, bus_if.busy_a};
                SEL_BUSYB: obs = {15'd0, bus_if.busy_b};
                default:   obs = {15'd0, bus_if.wb_pend};
            endcase
            check(e.tag, obs, e.exp);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        idle();
        bus_if.wb_addr  = '0;
        bus_if.wb_data  = '0;
        bus_if.iss_addr = '0;
        set_rd(4'd3, 4'd9);

        // Power-on reset state.
        #2;
        expect_out("por_rd_a", SEL_RDA, 16'h0000);
        expect_out("por_rd_b", SEL_RDB, 16'h0000);
        expect_out("por_busy_a", SEL_BUSYA, 16'h0);
        expect_out("por_pend", SEL_PEND, 16'h0);
        drain();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset mid-operation discards the staged write and busy bits.
        drive_iss(4'd3);
        tick();
        idle();
        drive_wb(4'd3, 16'hBEEF);
        tick();
        idle();
        set_rd(4'd3, 4'd3);
        expect_out("rst_pre_byp", SEL_RDA, 16'hBEEF);
        expect_out("rst_pre_pend", SEL_PEND, 16'h1);
        expect_out("rst_pre_busy", SEL_BUSYA, 16'h1);
        drain();
        #1;
        rst_n = 1'b0;
        expect_out("rst_rd_a", SEL_RDA, 16'h0000);
        expect_out("rst_pend", SEL_PEND, 16'h0);
        expect_out("rst_busy_a", SEL_BUSYA, 16'h0);
        drain();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        expect_out("rst_no_commit", SEL_RDA, 16'h0000);
        expect_out("rst_busy_after", SEL_BUSYB, 16'h0);
        drain();

        // Basic write then read via bypass, then via array.
        set_rd(4'd5, 4'd0);
        drive_wb(4'd5, 16'h1234);
        tick();
        idle();
        expect_out("basic_byp", SEL_RDA, 16'h1234);
        expect_out("basic_pend1", SEL_PEND, 16'h1);
        drain();
        tick();
        expect_out("basic_arr", SEL_RDA, 16'h1234);
        expect_out("basic_pend0", SEL_PEND, 16'h0);
        drain();

        // Bypass priority over the stale array value.
        set_rd(4'd7, 4'd7);
        drive_wb(4'd7, 16'h0001);
        tick();
        idle();
        tick();
        drive_wb(4'd7, 16'h00FF);
        expect_out("byp_before_a", SEL_RDA, 16'h0001);
        expect_out("byp_before_b", SEL_RDB, 16'h0001);
        drain();
        tick();
        idle();
        expect_out("byp_stage_a", SEL_RDA, 16'h00FF);
        expect_out("byp_stage_b", SEL_RDB, 16'h00FF);
        drain();
        tick();

        // Back-to-back writes, same address then a different one.
        set_rd(4'd2, 4'd4);
        drive_wb(4'd2, 16'hAAAA);
        tick();
        expect_out("b2b_first", SEL_RDA, 16'hAAAA);
        drain();
        drive_wb(4'd2, 16'h5555);
        tick();
        expect_out("b2b_second", SEL_RDA, 16'h5555);
        drain();
        drive_wb(4'd4, 16'h0F0F);
        tick();
        idle();
        expect_out("b2b_r2_arr", SEL_RDA, 16'h5555);
        expect_out("b2b_r4_byp", SEL_RDB, 16'h0F0F);
        drain();
        tick();
        expect_out("b2b_r2_final", SEL_RDA, 16'h5555);
        expect_out("b2b_r4_final", SEL_RDB, 16'h0F0F);
        drain();

        // Scoreboard lifecycle for r9.
        set_rd(4'd9, 4'd1);
        drive_iss(4'd9);
        tick();
        idle();
        expect_out("sb_set", SEL_BUSYA, 16'h1);
        drain();
        tick();
        expect_out("sb_hold", SEL_BUSYA, 16'h1);
        drain();
        drive_wb(4'd9, 16'h9999);
        tick();
        idle();
        expect_out("sb_staged", SEL_BUSYA, 16'h1);
        drain();
        tick();
        expect_out("sb_clear", SEL_BUSYA, 16'h0);
        expect_out("sb_data", SEL_RDA, 16'h9999);
        drain();

        // Same-register set and clear on one edge: set wins.
        drive_iss(4'd9);
        tick();
        idle();
        drive_wb(4'd9, 16'h9A9A);
        tick();
        idle();
        drive_iss(4'd9);
        tick();
        idle();
        expect_out("sb_setwins", SEL_BUSYA, 16'h1);
        expect_out("sb_setwins_d", SEL_RDA, 16'h9A9A);
        drain();

        // Different registers: set r1 while committing r9.
        drive_wb(4'd9, 16'h9B9B);
        tick();
        idle();
        drive_iss(4'd1);
        tick();
        idle();
        expect_out("sb_diff_r9", SEL_BUSYA, 16'h0);
        expect_out("sb_diff_r1", SEL_BUSYB, 16'h1);
        drain();
        drive_wb(4'd1, 16'h1111);
        tick();
        idle();
        tick();
        expect_out("sb_r1_clear", SEL_BUSYB, 16'h0);
        drain();

        // Sweep all registers with consecutive writes.
        for (int i = 0; i < 16; i++) begin
            drive_wb(4'(i), 16'h1000 + 16'(i));
            tick();
        end
        idle();
        tick();
        for (int i = 0; i < 16; i++) begin
            set_rd(4'(i), 4'(15 - i));
            expect_out($sformatf("sweep_a_r%0d", i), SEL_RDA, 16'h1000 + 16'(i));
            expect_out($sformatf("sweep_b_r%0d", 15 - i), SEL_RDB, 16'h1000 + 16'(15 - i));
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/regfile_wb.md
# regfile_wb

Write-back register file for the 16-bit datapath: consumes the selected result from the bus-to-regfile write-data selector, stages it one cycle in a write-back register, then commits it to a 16-entry array. Provides two combinational read ports with bypass from the staged write, plus a per-register busy scoreboard that the decode stage uses to stall on outstanding writes.

## Interface
- DATAWIDTH, `DATAWIDTH (16): data word width.
- ADDRWIDTH, 4: register address width; NREGS = 2**ADDRWIDTH = 16.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wb_valid  in  1  write request this cycle.
- wb_addr  in  ADDRWIDTH  destination register.
- wb_data  in  DATAWIDTH  write data (selector dout).
- iss_valid  in  1  decode issues an instruction that will write iss_addr.
- iss_addr  in  ADDRWIDTH  destination of the issued instruction.
- rd_addr_a, rd_addr_b  in  ADDRWIDTH  read addresses.
- rd_data_a, rd_data_b  out  DATAWIDTH  read data, combinational.
- busy_a, busy_b  out  1  scoreboard bit for rd_addr_a / rd_addr_b, combinational.
- wb_pend  out  1  staged write pending commit (registered).

## Operation
- Stage register: on each edge, pend_valid <= wb_valid; when wb_valid, pend_addr <= wb_addr, pend_data <= wb_data. wb_pend = pend_valid.
- Commit: on each edge with pend_valid=1, regs[pend_addr] <= pend_data. Commit and a new stage capture happen on the same edge (no stall; one write per cycle sustained).
- Read port (each identical): if pend_valid and pend_addr == rd_addr, rd_data = pend_data; else rd_data = regs[rd_addr]. wb_data in the current cycle is not bypassed.
- Scoreboard busy[NREGS]: on edge, set busy[iss_addr] when iss_valid; clear busy[pend_addr] when pend_valid (commit). Same register set and cleared on one edge -> set wins (busy stays 1). Different registers -> both take effect.
- busy_x = busy[rd_addr_x].
- Upstream guarantees at most one outstanding write per register (decode stalls on busy); the block does not count multiple outstanding writes.
- No hardwired-zero register; all 16 entries writable.
- Reset (rst_n=0, asynchronous): all regs = 0, busy = 0, pend_valid = 0, pend_addr = 0, pend_data = 0. Hence rd_data_a/b = 0, busy_a/b = 0, wb_pend = 0 during and immediately after reset. Reset mid-operation discards any staged write (never committed) and clears all busy bits.

## Timing
- wb_valid sampled at edge E: visible on read ports (via bypass) in cycle E..E+1, in array from edge E+1 onward. Read latency from array: zero (combinational).
- Back-to-back writes to the same address at edges E and E+1: reads after E+1 return the second value; array holds second value after E+2.
- Write at edge E with a read of the same address in the cycle before E: returns old value.
- Scoreboard: iss_valid at edge E -> busy visible after E; cleared at the edge that commits the matching write (one edge after its wb_valid capture).
- Release of rst_n is synchronised externally; first capture on the first rising edge with rst_n=1.

## Test plan
- Reset: write 0xBEEF to r3, assert rst_n=0 mid-cycle -> rd_data for r3 = 0x0000 immediately, wb_pend = 0, busy all 0; staged write not committed after release.
- Basic write/read: wb_valid, wb_addr=5, wb_data=0x1234 at edge 1 -> rd_data_a(addr 5)=0x1234 after edge 1 (bypass, wb_pend=1), still 0x1234 after edge 2 with wb_pend=0 (array).
- Bypass priority: r7=0x0001 committed, then write 0x00FF to r7 -> in the staging cycle rd_data_a and rd_data_b (both addr 7) = 0x00FF; in the cycle before the capture edge = 0x0001.
- Back-to-back: writes r2=0xAAAA then r2=0x5555 on consecutive edges, then r4=0x0F0F -> final r2=0x5555, r4=0x0F0F, no lost commit.
- Scoreboard: iss r9 at edge 1 -> busy=1; wb r9 at edge 3 -> busy still 1 after edge 3, 0 after edge 4. Simultaneous iss r9 and commit r9 on one edge -> busy stays 1; iss r1 with commit r9 -> busy[1]=1, busy[9]=0.
- Sweep: write r0..r15 with 0x1000+i on consecutive edges, read all via both ports -> each returns 0x1000+i.
